// File: rtl/draw_launch.sv
// DXYN draw sequencer: takes one request, launches the sprite engine on a free slot,
// and returns the collision flag as VF. Optional watchdog abort: define DRAW_WATCHDOG_EN.
module draw_launch #(
  parameter int unsigned SETTLE     = 3,
  parameter int unsigned WDOG_WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [7:0]  vx,
  input  logic [7:0]  vy,
  input  logic [3:0]  n,
  input  logic [15:0] i_reg,
  output logic        ack,
  output logic        done,
  output logic [7:0]  vf,
  output logic        err,
  output logic        draw_en,
  output logic [15:0] draw_i,
  output logic [10:0] draw_start_pix,
  output logic [3:0]  draw_nibbles,
  input  logic        draw_busy,
  input  logic        draw_col
);
  typedef enum logic [2:0] {
    ST_IDLE, ST_WAIT_FREE, ST_LAUNCH, ST_RUN, ST_SETTLE, ST_DONE
  } state_t;

  localparam logic [2:0] SETTLE_LD = 3'(SETTLE - 1);

  if (SETTLE < 1 || SETTLE > 7 || WDOG_WIDTH < 1) begin : g_param_chk
    $error("draw_launch: parameter out of range");
  end

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        acc_q, acc_d;
  logic        zero_q, zero_d;
  logic        vf_q, vf_d;
  logic        ack_q, ack_d;
  logic        done_q, done_d;
  logic        en_q, en_d;
  logic [15:0] i_q, i_d;
  logic [10:0] pix_q, pix_d;
  logic [3:0]  nib_q, nib_d;

  // Coordinates wrap to 64x32, so the high bits of vx/vy are dropped on purpose.
  logic unused_hi;
  assign unused_hi = ^{vx[7:6], vy[7:5]};

`ifdef DRAW_WATCHDOG_EN
  logic                  err_q, err_d;
  logic [WDOG_WIDTH-1:0] wd_q, wd_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
      wd_q  <= '0;
    end else begin
      err_q <= err_d;
      wd_q  <= wd_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    zero_d  = zero_q;
    vf_d    = vf_q;
    i_d     = i_q;
    pix_d   = pix_q;
    nib_d   = nib_q;
    ack_d   = 1'b0;
`ifdef DRAW_WATCHDOG_EN
    err_d   = err_q;
    wd_d    = '0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          ack_d  = 1'b1;
          i_d    = i_reg;
          pix_d  = {vy[4:0], vx[5:0]};
          nib_d  = n;
          acc_d  = 1'b0;
          vf_d   = 1'b0;
          zero_d = (n == 4'd0);
`ifdef DRAW_WATCHDOG_EN
          err_d  = 1'b0;
`endif
          // Zero-height draws never launch; one pass through SETTLE lines done up one cycle after ack.
          if (n == 4'd0) begin
            state_d = ST_SETTLE;
            cnt_d   = 3'd0;
          end else begin
            state_d = ST_WAIT_FREE;
          end
        end
      end
      ST_WAIT_FREE: if (!draw_busy) state_d = ST_LAUNCH;
      ST_LAUNCH:    state_d = ST_RUN;
      ST_RUN: begin
        acc_d = acc_q | draw_col;
        if (!draw_busy) begin
          state_d = ST_SETTLE;
          cnt_d   = SETTLE_LD;
        end
      end
      ST_SETTLE: begin
        if (!zero_q) acc_d = acc_q | draw_col;
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd0) begin
          state_d = ST_DONE;
          cnt_d   = 3'd0;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
`ifdef DRAW_WATCHDOG_EN
    if ((state_q == ST_WAIT_FREE || state_q == ST_RUN) && state_d == state_q) begin
      if (&wd_q) begin
        state_d = ST_DONE;
        err_d   = 1'b1;
      end else begin
        wd_d = wd_q + WDOG_WIDTH'(1);
      end
    end
`endif
    if (state_d == ST_DONE) vf_d = acc_d;
    en_d   = (state_d == ST_LAUNCH);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      acc_q   <= 1'b0;
      zero_q  <= 1'b0;
      vf_q    <= 1'b0;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
      en_q    <= 1'b0;
      i_q     <= 16'd0;
      pix_q   <= 11'd0;
      nib_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      zero_q  <= zero_d;
      vf_q    <= vf_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      en_q    <= en_d;
      i_q     <= i_d;
      pix_q   <= pix_d;
      nib_q   <= nib_d;
    end
  end

  assign ack            = ack_q;
  assign done           = done_q;
  assign vf             = {7'b0, vf_q};
  assign draw_en        = en_q;
  assign draw_i         = i_q;
  assign draw_start_pix = pix_q;
  assign draw_nibbles   = nib_q;
endmodule

// File: tb/tb_draw_launch.sv
// Bench for draw_launch: timestamp-based model of the request/launch/settle rules plus directed cases.
module tb_draw_launch;
  localparam int SETTLE = 3;
  localparam int WDW    = 6;
`ifdef DRAW_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif
  localparam int WD_MAX = (1 << WDW) - 1;

  logic        clk = 1'b0, rst = 1'b1, req = 1'b0, draw_busy = 1'b0, draw_col = 1'b0;
  logic [7:0]  vx = 8'd0, vy = 8'd0;
  logic [3:0]  n = 4'd0;
  logic [15:0] i_reg = 16'd0;
  logic        ack, done, err, draw_en;
  logic [7:0]  vf;
  logic [15:0] draw_i;
  logic [10:0] draw_start_pix;
  logic [3:0]  draw_nibbles;

  draw_launch #(.SETTLE(SETTLE), .WDOG_WIDTH(WDW)) dut (
    .clk(clk), .rst(rst), .req(req), .vx(vx), .vy(vy), .n(n), .i_reg(i_reg),
    .ack(ack), .done(done), .vf(vf), .err(err), .draw_en(draw_en),
    .draw_i(draw_i), .draw_start_pix(draw_start_pix), .draw_nibbles(draw_nibbles),
    .draw_busy(draw_busy), .draw_col(draw_col)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_checks = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: edge e samples inputs; the window after edge e is cycle e+1.
  bit          started = 0, inflight = 0, waiting = 0, running = 0, settling = 0;
  int          idle_from = 0, wait_from = 0, run_from = 0, fall_e = 0;
  int          ack_at = -1, en_at = -1, done_at = -1, m_e, m_w;
  bit          acc = 0, m_err = 0;
  logic [15:0] cap_i;
  logic [10:0] cap_pix;
  logic [3:0]  cap_nib;
  logic        exp_ack, exp_en, exp_done, exp_err, vf_chk;
  logic [7:0]  exp_vf;
  logic [15:0] exp_i;
  logic [10:0] exp_pix;
  logic [3:0]  exp_nib;

  always @(posedge clk) begin
    m_e = cyc;
    m_w = m_e + 1;
    if (rst) begin
      started = 1; inflight = 0; waiting = 0; running = 0; settling = 0;
      ack_at = -1; en_at = -1; done_at = -1; acc = 0; m_err = 0;
      idle_from = m_w;
      exp_ack = 0; exp_en = 0; exp_done = 0; exp_err = 0;
      vf_chk = 1; exp_vf = 8'h00; exp_i = 16'h0; exp_pix = 11'h0; exp_nib = 4'h0;
    end else begin
      if (!inflight && m_e >= idle_from && req) begin
        inflight = 1; ack_at = m_w; acc = 0; m_err = 0;
        cap_i = i_reg; cap_pix = {vy[4:0], vx[5:0]}; cap_nib = n;
        if (n == 4'd0) done_at = m_e + 2;
        else begin waiting = 1; wait_from = m_w; end
      end else if (waiting && m_e >= wait_from) begin
        if (!draw_busy) begin
          waiting = 0; running = 1; en_at = m_w; run_from = m_e + 2;
        end else if (WD && m_e == wait_from + WD_MAX) begin
          waiting = 0; done_at = m_w; m_err = 1;
        end
      end else if (running && m_e >= run_from) begin
        acc = acc | draw_col;
        if (!draw_busy) begin
          running = 0; settling = 1; fall_e = m_e; done_at = m_e + SETTLE + 1;
        end else if (WD && m_e == run_from + WD_MAX) begin
          running = 0; done_at = m_w; m_err = 1;
        end
      end else if (settling && m_e > fall_e) begin
        acc = acc | draw_col;
        if (m_e == fall_e + SETTLE) settling = 0;
      end
      exp_ack  = (m_w == ack_at);
      exp_en   = (m_w == en_at);
      exp_done = (m_w == done_at);
      if (m_w == ack_at) begin
        vf_chk = 0; exp_err = 0; exp_i = cap_i; exp_pix = cap_pix; exp_nib = cap_nib;
      end
      if (m_w == done_at) begin
        vf_chk = 1; exp_vf = {7'b0, acc}; exp_err = m_err; inflight = 0; idle_from = m_w + 1;
      end
    end
    cyc = m_w;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("ack", ack, exp_ack);
      chk("draw_en", draw_en, exp_en);
      chk("done", done, exp_done);
      chk("err", err, exp_err);
      chk("draw_i", draw_i, exp_i);
      chk("draw_start_pix", draw_start_pix, exp_pix);
      chk("draw_nibbles", draw_nibbles, exp_nib);
      if (vf_chk) chk("vf", vf, exp_vf);
    end
  end

  task automatic issue(input logic [7:0] x, input logic [7:0] y, input logic [3:0] nn,
                       input logic [15:0] ii, output int e_req);
    bit got;
    got = 0;
    vx = x; vy = y; n = nn; i_reg = ii; req = 1'b1; e_req = cyc;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      got = ack;
    end
    req = 1'b0;
    vx = ~x; vy = ~y; n = ~nn; i_reg = ~ii;
    chk("ack_seen", got, 1'b1);
  endtask

  task automatic wait_done(input int bound);
    bit got;
    got = 0;
    for (int k = 0; k < bound && !got; k++) begin
      @(negedge clk);
      got = done;
    end
    chk("done_seen", got, 1'b1);
  endtask

  initial begin
    int e0, wf;
    repeat (2) @(negedge clk);
    chk("rst_ack", ack, 0); chk("rst_done", done, 0); chk("rst_en", draw_en, 0);
    chk("rst_vf", vf, 8'h00); chk("rst_pix", draw_start_pix, 11'h0);
    rst = 1'b0;
    @(negedge clk);

    // basic launch, no collision
    issue(8'h45, 8'h27, 4'd5, 16'h0300, e0);
    chk("basic_ack_cycle", cyc, e0 + 1);
    @(negedge clk);
    chk("basic_en", draw_en, 1'b1);
    chk("basic_en_cycle", cyc, e0 + 2);
    chk("basic_pix", draw_start_pix, 11'b00111_000101);
    chk("basic_nib", draw_nibbles, 4'd5);
    chk("basic_i", draw_i, 16'h0300);
    draw_busy = 1'b1;
    repeat (4) @(negedge clk);
    draw_busy = 1'b0; wf = cyc;
    wait_done(20);
    chk("basic_done_cycle", cyc, wf + SETTLE + 1);
    chk("basic_vf", vf, 8'h00);
    @(negedge clk);

    // single-cycle collision during RUN
    issue(8'h10, 8'h08, 4'd3, 16'h0210, e0);
    @(negedge clk);
    draw_busy = 1'b1;
    repeat (2) @(negedge clk);
    draw_col = 1'b1; @(negedge clk); draw_col = 1'b0; @(negedge clk);
    draw_busy = 1'b0;
    wait_done(20);
    chk("col_vf", vf, 8'h01);
    @(negedge clk);

    // wrapped coordinates, collision two cycles after busy falls
    issue(8'hFF, 8'hFF, 4'hF, 16'hFFFF, e0);
    @(negedge clk);
    chk("wrap_pix", draw_start_pix, 11'h7FF);
    draw_busy = 1'b1;
    repeat (3) @(negedge clk);
    draw_busy = 1'b0;
    repeat (2) @(negedge clk);
    draw_col = 1'b1; @(negedge clk); draw_col = 1'b0; @(negedge clk);
    chk("late_done", done, 1'b1);
    chk("late_vf", vf, 8'h01);
    @(negedge clk);

    // collision arriving one cycle after the settle window is ignored
    issue(8'h01, 8'h02, 4'd2, 16'h0123, e0);
    @(negedge clk);
    draw_busy = 1'b1;
    repeat (2) @(negedge clk);
    draw_busy = 1'b0;
    repeat (4) @(negedge clk);
    chk("tooLate_done", done, 1'b1);
    draw_col = 1'b1; @(negedge clk); draw_col = 1'b0;
    chk("tooLate_vf", vf, 8'h00);
    @(negedge clk);

    // busy (vsync) at request time
    draw_busy = 1'b1;
    @(negedge clk);
    issue(8'h20, 8'h10, 4'd4, 16'h0500, e0);
    repeat (38) begin
      @(negedge clk);
      chk("vsync_no_en", draw_en, 1'b0);
    end
    draw_busy = 1'b0;
    @(negedge clk);
    chk("vsync_en", draw_en, 1'b1);
    draw_busy = 1'b1;
    repeat (3) @(negedge clk);
    draw_busy = 1'b0;
    wait_done(20);
    chk("vsync_vf", vf, 8'h00);
    @(negedge clk);

    // n=0: immediate done, no launch, collisions ignored
    draw_busy = 1'b1; draw_col = 1'b1;
    issue(8'h12, 8'h34, 4'd0, 16'h0400, e0);
    chk("n0_ack_cycle", cyc, e0 + 1);
    @(negedge clk);
    chk("n0_done", done, 1'b1);
    chk("n0_done_cycle", cyc, e0 + 2);
    chk("n0_vf", vf, 8'h00);
    draw_busy = 1'b0; draw_col = 1'b0;
    @(negedge clk);

    // reset during RUN, then a request waits out the still-running draw
    issue(8'h05, 8'h06, 4'd7, 16'h0600, e0);
    @(negedge clk);
    draw_busy = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    chk("mrst_ack", ack, 0); chk("mrst_done", done, 0); chk("mrst_en", draw_en, 0);
    chk("mrst_vf", vf, 8'h00); chk("mrst_i", draw_i, 16'h0);
    chk("mrst_pix", draw_start_pix, 11'h0); chk("mrst_nib", draw_nibbles, 4'h0);
    issue(8'h07, 8'h08, 4'd1, 16'h0700, e0);
    repeat (5) begin
      @(negedge clk);
      chk("mrst_no_en", draw_en, 1'b0);
    end
    draw_busy = 1'b0;
    @(negedge clk);
    chk("mrst_en_after", draw_en, 1'b1);
    draw_busy = 1'b1;
    repeat (2) @(negedge clk);
    draw_col = 1'b1; draw_busy = 1'b0; @(negedge clk); draw_col = 1'b0;
    wait_done(20);
    chk("mrst_vf_after", vf, 8'h01);
    @(negedge clk);

`ifdef DRAW_WATCHDOG_EN
    // stuck busy: watchdog abort
    draw_busy = 1'b1;
    issue(8'h09, 8'h0A, 4'd3, 16'h0800, e0);
    wait_done(WD_MAX + 10);
    chk("wdog_err", err, 1'b1);
    chk("wdog_vf", vf, 8'h00);
    draw_busy = 1'b0;
    @(negedge clk);
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
